latch_id_ex: RTL

ID/EX pipeline register of the 5-stage MIPS pipeline, with integrated load-use hazard detection.
- Captures decoded operands, register indices and control bits from ID and presents them to EX.
- The forwarding unit consumes o_rs_EX/o_rt_EX, and the MEM/WB copies of o_rd_EX/o_write_reg_EX, downstream.
- Detects load-use hazards, requests a stall of PC and IF/ID, inserts bubbles on stall/flush, freezes on debug halt, and counts inserted load-use bubbles.

---
 rtl/latch_id_ex.sv | 109 ++++++++++
 1 files changed

// File: rtl/latch_id_ex.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// debug halt and a saturating count of inserted load-use bubbles.
module latch_id_ex #(
  parameter int NB_DATA   = 32,
  parameter int NB_REG    = 5,
  parameter int NB_ALU_OP = 6,
  parameter int NB_COUNT  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_halt,
  input  logic                 i_flush,
  input  logic                 i_clr_count,
  input  logic [NB_REG-1:0]    i_rs_ID,
  input  logic [NB_REG-1:0]    i_rt_ID,
  input  logic [NB_REG-1:0]    i_rd_ID,
  input  logic                 i_uses_rs_ID,
  input  logic                 i_uses_rt_ID,
  input  logic [NB_DATA-1:0]   i_data_rs_ID,
  input  logic [NB_DATA-1:0]   i_data_rt_ID,
  input  logic [NB_DATA-1:0]   i_inm_ID,
  input  logic [NB_ALU_OP-1:0] i_alu_op_ID,
  input  logic                 i_alu_src_ID,
  input  logic                 i_write_reg_ID,
  input  logic                 i_mem_read_ID,
  input  logic                 i_mem_write_ID,
  input  logic                 i_mem_to_reg_ID,
  output logic [NB_REG-1:0]    o_rs_EX,
  output logic [NB_REG-1:0]    o_rt_EX,
  output logic [NB_REG-1:0]    o_rd_EX,
  output logic [NB_DATA-1:0]   o_data_rs_EX,
  output logic [NB_DATA-1:0]   o_data_rt_EX,
  output logic [NB_DATA-1:0]   o_inm_EX,
  output logic [NB_ALU_OP-1:0] o_alu_op_EX,
  output logic                 o_alu_src_EX,
  output logic                 o_write_reg_EX,
  output logic                 o_mem_read_EX,
  output logic                 o_mem_write_EX,
  output logic                 o_mem_to_reg_EX,
  output logic                 o_stall,
  output logic [NB_COUNT-1:0]  o_bubble_count
);

  localparam logic [NB_COUNT-1:0] COUNT_MAX = '1;

  logic rs_hit, rt_hit, bubble;

  // Load in EX whose destination is read by the instruction now in ID.
  assign rs_hit  = i_uses_rs_ID && (o_rd_EX == i_rs_ID);
  assign rt_hit  = i_uses_rt_ID && (o_rd_EX == i_rt_ID);
  assign o_stall = o_mem_read_EX && (o_rd_EX != '0) && (rs_hit || rt_hit);
  assign bubble  = i_flush || o_stall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rs_EX         <= '0;
      o_rt_EX         <= '0;
      o_rd_EX         <= '0;
      o_data_rs_EX    <= '0;
      o_data_rt_EX    <= '0;
      o_inm_EX        <= '0;
      o_alu_op_EX     <= '0;
      o_alu_src_EX    <= 1'b0;
      o_write_reg_EX  <= 1'b0;
      o_mem_read_EX   <= 1'b0;
      o_mem_write_EX  <= 1'b0;
      o_mem_to_reg_EX <= 1'b0;
    end else if (!i_halt) begin
      // Operand fields are don't-care in a bubble, so they always load.
      o_data_rs_EX <= i_data_rs_ID;
      o_data_rt_EX <= i_data_rt_ID;
      o_inm_EX     <= i_inm_ID;
      if (bubble) begin
        o_rs_EX         <= '0;
        o_rt_EX         <= '0;
        o_rd_EX         <= '0;
        o_alu_op_EX     <= '0;
        o_alu_src_EX    <= 1'b0;
        o_write_reg_EX  <= 1'b0;
        o_mem_read_EX   <= 1'b0;
        o_mem_write_EX  <= 1'b0;
        o_mem_to_reg_EX <= 1'b0;
      end else begin
        o_rs_EX         <= i_rs_ID;
        o_rt_EX         <= i_rt_ID;
        o_rd_EX         <= i_rd_ID;
        o_alu_op_EX     <= i_alu_op_ID;
        o_alu_src_EX    <= i_alu_src_ID;
        // Forwarding assumes rd=0 never carries a register write.
        o_write_reg_EX  <= i_write_reg_ID && (i_rd_ID != '0);
        o_mem_read_EX   <= i_mem_read_ID;
        o_mem_write_EX  <= i_mem_write_ID;
        o_mem_to_reg_EX <= i_mem_to_reg_ID;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_bubble_count <= '0;
    end else if (!i_halt) begin
      if (i_clr_count)
        o_bubble_count <= '0;
      else if (o_stall && !i_flush && o_bubble_count != COUNT_MAX)
        o_bubble_count <= o_bubble_count + 1'b1;
    end
  end

endmodule
